// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit for the Execute stage. An operation is
// accepted with a start pulse. The unit then stays busy while it runs, and
// reports the result with a one-cycle done pulse.
//
// Multiply uses shift-add over a 2*DATA_W product register. Divide uses
// restoring shift-subtract. STEP_BITS bits are retired per CALC cycle.
//
// Parameters
//   DATA_W    operand/result width (even, >= 8)
//   STEP_BITS bits retired per CALC cycle (1, 2 or 4; divides DATA_W)
//   RD_W      destination tag width
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   start   issue request, sampled while busy=0
//   op      RV32M funct3 (0 MUL .. 7 REMU)
//   opa     rs1 operand
//   opb     rs2 operand
//   rd_in   destination tag
//   flush   abort the in-flight operation
//   busy    operation in flight
//   done    one-cycle result-valid pulse
//   result  result, held until the next completion
//   rd_out  tag of the completed operation
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int DATA_W    = 32,
    parameter int STEP_BITS = 1,
    parameter int RD_W      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] opa,
    input  logic [DATA_W-1:0] opb,
    input  logic [RD_W-1:0]   rd_in,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [RD_W-1:0]   rd_out
);

    localparam int N_STEPS = DATA_W / STEP_BITS;
    localparam int CNT_W   = $clog2(N_STEPS) + 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(N_STEPS - 1);
    localparam logic [DATA_W-1:0] ZERO_W   = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] ONES_W   = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Two's-complement negation of a DATA_W value.
    function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v);
        return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
    endfunction

    // Two's-complement negation of a 2*DATA_W value.
    function automatic logic [2*DATA_W-1:0] neg_2w(input logic [2*DATA_W-1:0] v);
        return ~v + {{(2*DATA_W-1){1'b0}}, 1'b1};
    endfunction

    // STEP_BITS shift-add iterations. hi is the running partial product and
    // lo is the multiplier, which is shifted out as product bits shift in.
    function automatic logic [2*DATA_W-1:0] mul_steps(
        input logic [DATA_W-1:0] hi,
        input logic [DATA_W-1:0] lo,
        input logic [DATA_W-1:0] mcand
    );
        logic [DATA_W:0]   sum;
        logic [DATA_W-1:0] h;
        logic [DATA_W-1:0] l;
        h = hi;
        l = lo;
        for (int i = 0; i < STEP_BITS; i++) begin
            if (l[0]) begin
                sum = {1'b0, h} + {1'b0, mcand};
            end else begin
                sum = {1'b0, h};
            end
            l = {sum[0], l[DATA_W-1:1]};
            h = sum[DATA_W:1];
        end
        return {h, l};
    endfunction

    // STEP_BITS restoring-division iterations. hi is the partial remainder and
    // lo is the dividend, which is shifted out as quotient bits shift in.
    function automatic logic [2*DATA_W-1:0] div_steps(
        input logic [DATA_W-1:0] hi,
        input logic [DATA_W-1:0] lo,
        input logic [DATA_W-1:0] dvsr
    );
        logic [DATA_W:0]   shifted;
        logic [DATA_W:0]   diff;
        logic [DATA_W-1:0] h;
        logic [DATA_W-1:0] l;
        h = hi;
        l = lo;
        for (int i = 0; i < STEP_BITS; i++) begin
            shifted = {h, l[DATA_W-1]};
            diff    = shifted - {1'b0, dvsr};
            // Bit DATA_W of diff is set only when the trial subtraction went negative.
            if (!diff[DATA_W]) begin
                h = diff[DATA_W-1:0];
                l = {l[DATA_W-2:0], 1'b1};
            end else begin
                h = shifted[DATA_W-1:0];
                l = {l[DATA_W-2:0], 1'b0};
            end
        end
        return {h, l};
    endfunction

    state_t              state_r;
    logic [2:0]          op_r;
    logic [RD_W-1:0]     rd_r;
    logic                neg_a_r;
    logic                neg_b_r;
    logic [DATA_W-1:0]   opnd_r;
    logic [DATA_W-1:0]   hi_r;
    logic [DATA_W-1:0]   lo_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                special_r;
    logic [DATA_W-1:0]   spec_val_r;
    logic                busy_r;
    logic                done_r;
    logic [DATA_W-1:0]   result_r;
    logic [RD_W-1:0]     rd_out_r;

    logic                a_signed_s;
    logic                b_signed_s;
    logic                neg_a_s;
    logic                neg_b_s;
    logic [DATA_W-1:0]   a_mag_s;
    logic [DATA_W-1:0]   b_mag_s;
    logic                div_zero_s;
    logic                ovf_s;
    logic                special_s;
    logic [DATA_W-1:0]   spec_val_s;
    logic                accept_s;
    logic [2*DATA_W-1:0] step_s;
    logic [2*DATA_W-1:0] prod_fix_s;
    logic [DATA_W-1:0]   quo_fix_s;
    logic [DATA_W-1:0]   rem_fix_s;
    logic [DATA_W-1:0]   fix_val_s;

    // Operand signedness per opcode.
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (op)
            OP_MULH:   begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            OP_MULHSU: begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
            OP_DIV:    begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            OP_REM:    begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            default:   begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
        endcase
    end

    assign neg_a_s = a_signed_s & opa[DATA_W-1];
    assign neg_b_s = b_signed_s & opb[DATA_W-1];
    // The most-negative value maps to 2^(DATA_W-1), which still fits unsigned.
    assign a_mag_s = neg_a_s ? neg_w(opa) : opa;
    assign b_mag_s = neg_b_s ? neg_w(opb) : opb;

    assign div_zero_s = op[2] & (opb == ZERO_W);
    assign ovf_s      = ((op == OP_DIV) | (op == OP_REM)) & (opa == MOST_NEG) & (opb == ONES_W);
    assign special_s  = div_zero_s | ovf_s;

    // Fixed results for divide-by-zero and signed overflow; op[1] marks REM/REMU.
    always_comb begin
        if (div_zero_s) begin
            spec_val_s = op[1] ? opa : ONES_W;
        end else if (ovf_s) begin
            spec_val_s = op[1] ? ZERO_W : opa;
        end else begin
            spec_val_s = ZERO_W;
        end
    end

    // A flush in the same cycle cancels the issue request.
    assign accept_s = start & ~flush & ((state_r == S_IDLE) | (state_r == S_DONE));

    // One CALC cycle of the selected algorithm.
    always_comb begin
        if (op_r[2]) begin
            step_s = div_steps(hi_r, lo_r, opnd_r);
        end else begin
            step_s = mul_steps(hi_r, lo_r, opnd_r);
        end
    end

    // Sign correction and half/quotient/remainder selection for the FIX cycle.
    always_comb begin
        prod_fix_s = (neg_a_r ^ neg_b_r) ? neg_2w({hi_r, lo_r}) : {hi_r, lo_r};
        quo_fix_s  = (neg_a_r ^ neg_b_r) ? neg_w(lo_r) : lo_r;
        rem_fix_s  = neg_a_r ? neg_w(hi_r) : hi_r;
        fix_val_s  = ZERO_W;
        if (special_r) begin
            fix_val_s = spec_val_r;
        end else begin
            case (op_r)
                OP_MUL:    fix_val_s = prod_fix_s[DATA_W-1:0];
                OP_MULH:   fix_val_s = prod_fix_s[2*DATA_W-1:DATA_W];
                OP_MULHSU: fix_val_s = prod_fix_s[2*DATA_W-1:DATA_W];
                OP_MULHU:  fix_val_s = prod_fix_s[2*DATA_W-1:DATA_W];
                OP_DIV:    fix_val_s = quo_fix_s;
                OP_DIVU:   fix_val_s = quo_fix_s;
                OP_REM:    fix_val_s = rem_fix_s;
                OP_REMU:   fix_val_s = rem_fix_s;
                default:   fix_val_s = ZERO_W;
            endcase
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            op_r       <= 3'd0;
            rd_r       <= {RD_W{1'b0}};
            neg_a_r    <= 1'b0;
            neg_b_r    <= 1'b0;
            opnd_r     <= ZERO_W;
            hi_r       <= ZERO_W;
            lo_r       <= ZERO_W;
            cnt_r      <= {CNT_W{1'b0}};
            special_r  <= 1'b0;
            spec_val_r <= ZERO_W;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            result_r   <= ZERO_W;
            rd_out_r   <= {RD_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    done_r <= 1'b0;
                    if (accept_s) begin
                        op_r       <= op;
                        rd_r       <= rd_in;
                        neg_a_r    <= neg_a_s;
                        neg_b_r    <= neg_b_s;
                        // Multiply: opnd is the multiplicand and lo holds the multiplier.
                        // Divide: opnd is the divisor and lo holds the dividend.
                        opnd_r     <= op[2] ? b_mag_s : a_mag_s;
                        lo_r       <= op[2] ? a_mag_s : b_mag_s;
                        hi_r       <= ZERO_W;
                        cnt_r      <= CNT_LOAD;
                        special_r  <= special_s;
                        spec_val_r <= spec_val_s;
                        busy_r     <= 1'b1;
                        state_r    <= special_s ? S_FIX : S_CALC;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end else begin
                        hi_r <= step_s[2*DATA_W-1:DATA_W];
                        lo_r <= step_s[DATA_W-1:0];
                        if (cnt_r == {CNT_W{1'b0}}) begin
                            state_r <= S_FIX;
                        end else begin
                            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end else begin
                        result_r <= fix_val_s;
                        rd_out_r <= rd_r;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        state_r  <= S_DONE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign rd_out = rd_out_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Directed and randomised checks of muldiv_unit. It uses a 32-bit/1-step
// instance and a 16-bit/4-step instance. Expected results are queued when an
// operation is issued and are compared when done pulses.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        rst, start, flush;
    logic [2:0]  op;
    logic [31:0] opa, opb;
    logic [4:0]  rd_in;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    // 16-bit, 4 bits/cycle instance
    logic        rst16, start16, flush16;
    logic [2:0]  op16;
    logic [15:0] opa16, opb16;
    logic [4:0]  rd16;
    logic        busy16, done16;
    logic [15:0] result16;
    logic [4:0]  rd_out16;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    muldiv_unit u_dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
        .rd_in(rd_in), .flush(flush), .busy(busy), .done(done),
        .result(result), .rd_out(rd_out)
    );

    muldiv_unit #(.DATA_W(16), .STEP_BITS(4), .RD_W(5)) u_dut16 (
        .clk(clk), .rst(rst16), .start(start16), .op(op16), .opa(opa16), .opb(opb16),
        .rd_in(rd16), .flush(flush16), .busy(busy16), .done(done16),
        .result(result16), .rd_out(rd_out16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent reference built on SystemVerilog 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb, sbu, q;
        logic [63:0] ua, ub, p;
        logic [31:0] r;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        sbu = {32'd0, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        r   = 32'd0;
        case (o)
            3'd0: begin p = ua * ub;  r = p[31:0];  end
            3'd1: begin p = sa * sb;  r = p[63:32]; end
            3'd2: begin p = sa * sbu; r = p[63:32]; end
            3'd3: begin p = ua * ub;  r = p[63:32]; end
            3'd4: begin if (b == 32'd0) r = 32'hFFFFFFFF; else begin q = sa / sb; r = q[31:0]; end end
            3'd5: begin if (b == 32'd0) r = 32'hFFFFFFFF; else begin p = ua / ub; r = p[31:0]; end end
            3'd6: begin if (b == 32'd0) r = a; else begin q = sa % sb; r = q[31:0]; end end
            default: begin if (b == 32'd0) r = a; else begin p = ua % ub; r = p[31:0]; end end
        endcase
        return r;
    endfunction

    // Issue on the 32-bit instance from a negedge. Return at the negedge where done is seen.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_res,
                          input int exp_lat, input string tag);
        int   k;
        int   busy_errs;
        exp_t e;
        sb_q.push_back('{exp_res, rd});
        op = o; opa = a; opb = b; rd_in = rd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        busy_errs = 0;
        while (done !== 1'b1 && k < 100) begin
            if (busy !== 1'b1) busy_errs++;
            @(negedge clk);
            k++;
        end
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " latency"}, 64'(k), 64'(exp_lat));
        check({tag, " busy_while_running"}, 64'(busy_errs), 64'd0);
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, " result"}, 64'(result), 64'(e.res));
            check({tag, " rd_out"}, 64'(rd_out), 64'(e.rd));
        end
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb, res_cap;
        logic [4:0]  rd_cap;
        int          dones, lat, k;
        exp_t        e;

        rst = 1'b1; start = 1'b1; flush = 1'b0; op = 3'd0; opa = 32'd5; opb = 32'd5; rd_in = 5'd1;
        rst16 = 1'b1; start16 = 1'b1; flush16 = 1'b0; op16 = 3'd0; opa16 = 16'd0; opb16 = 16'd0; rd16 = 5'd0;
        repeat (3) @(negedge clk);
        // Reset state, even with start held high
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst result", 64'(result), 64'd0);
        check("rst rd_out", 64'(rd_out), 64'd0);
        check("rst16 busy", 64'(busy16), 64'd0);
        check("rst16 result", 64'(result16), 64'd0);
        rst = 1'b0; rst16 = 1'b0; start = 1'b0; start16 = 1'b0;
        @(negedge clk);
        check("post-rst busy", 64'(busy), 64'd0);

        // Directed RV32M cases, issued back-to-back from the DONE cycle
        run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 34, "mul");
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'hFFFFFFFE, 34, "mulhu");
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'h00000000, 34, "mulh");
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'hFFFFFFFF, 34, "mulhsu");
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFD, 34, "div");
        run_op(3'd6, 32'hFFFFFFF9, 32'd2, 5'd11, 32'hFFFFFFFF, 34, "rem");
        run_op(3'd5, 32'd100, 32'd7, 5'd12, 32'd14, 34, "divu");
        run_op(3'd7, 32'd100, 32'd7, 5'd13, 32'd2, 34, "remu");
        run_op(3'd5, 32'd123, 32'd0, 5'd14, 32'hFFFFFFFF, 2, "divu_by0");
        run_op(3'd6, 32'd123, 32'd0, 5'd15, 32'd123, 2, "rem_by0");
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 2, "div_ovf");
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0, 2, "rem_ovf");

        // Random operations against the reference model
        for (int i = 0; i < 8; i++) begin
            ro = 3'($urandom_range(7, 0));
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1000, 1));
            if (i == 5) rb = 32'd0;
            lat = ((ro[2] && rb == 32'd0) ||
                   ((ro == 3'd4 || ro == 3'd6) && ra == 32'h80000000 && rb == 32'hFFFFFFFF)) ? 2 : 34;
            run_op(ro, ra, rb, 5'(i + 20), ref_model(ro, ra, rb), lat, "random");
        end

        // A start during busy is ignored: exactly one done
        sb_q.push_back('{32'd14, 5'd9});
        op = 3'd5; opa = 32'd100; opb = 32'd7; rd_in = 5'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0; lat = 0; res_cap = 32'd0; rd_cap = 5'd0;
        for (int c = 1; c <= 60; c++) begin
            if (done === 1'b1) begin
                dones++; lat = c; res_cap = result; rd_cap = rd_out;
            end
            if (c == 5) begin
                start = 1'b1; op = 3'd0; opa = 32'd3; opb = 32'd3; rd_in = 5'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("ignore_start dones", 64'(dones), 64'd1);
        check("ignore_start latency", 64'(lat), 64'd34);
        e = sb_q.pop_front();
        check("ignore_start result", 64'(res_cap), 64'(e.res));
        check("ignore_start rd_out", 64'(rd_cap), 64'(e.rd));
        check("result held", 64'(result), 64'd14);

        // Flush a DIV in CALC at cycle +10
        op = 3'd4; opa = 32'hFFFFFFF9; opb = 32'd2; rd_in = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int c = 1; c <= 10; c++) begin
            if (done === 1'b1) dones++;
            if (c == 10) flush = 1'b1;
            @(negedge clk);
        end
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush done", 64'(done + dones), 64'd0);
        check("flush result kept", 64'(result), 64'd14);
        check("flush rd_out kept", 64'(rd_out), 64'd9);
        @(negedge clk);
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, 5'd3, 32'hFFFFFFFD, 34, "after_flush");

        // Flush in IDLE cancels a start in the same cycle
        @(negedge clk);
        op = 3'd0; opa = 32'd2; opb = 32'd2; rd_in = 5'd4; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("idle_flush busy", 64'(busy), 64'd0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        check("idle_flush dones", 64'(dones), 64'd0);
        check("idle_flush result", 64'(result), 64'hFFFFFFFD);

        // Flush during DONE does not suppress the pulse
        sb_q.push_back('{32'hFFFFFFFF, 5'd2});
        op = 3'd5; opa = 32'd5; opb = 32'd0; rd_in = 5'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_flush busy", 64'(busy), 64'd1);
        @(negedge clk);
        e = sb_q.pop_front();
        check("done_flush done", 64'(done), 64'd1);
        check("done_flush result", 64'(result), 64'(e.res));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("done_flush pulse width", 64'(done), 64'd0);

        // 16-bit, 4 bits per cycle: MUL 300*200
        sb_q.push_back('{32'h0000EA60, 5'd4});
        op16 = 3'd0; opa16 = 16'd300; opb16 = 16'd200; rd16 = 5'd4; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        k = 1;
        while (done16 !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        e = sb_q.pop_front();
        check("mul16 latency", 64'(k), 64'd6);
        check("mul16 result", 64'(result16), 64'(e.res));
        check("mul16 rd_out", 64'(rd_out16), 64'(e.rd));

        // Reset in the middle of CALC
        @(negedge clk);
        op16 = 3'd5; opa16 = 16'd1000; opb16 = 16'd3; rd16 = 5'd9; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        check("calc16 busy", 64'(busy16), 64'd1);
        @(negedge clk);
        rst16 = 1'b1;
        @(negedge clk);
        rst16 = 1'b0;
        check("midrst busy", 64'(busy16), 64'd0);
        check("midrst done", 64'(done16), 64'd0);
        check("midrst result", 64'(result16), 64'd0);
        check("midrst rd_out", 64'(rd_out16), 64'd0);
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            if (done16 === 1'b1) dones++;
            @(negedge clk);
        end
        check("midrst no done", 64'(dones), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
